multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Sequential main-control FSM that breaks each RV32 instruction into phases.
- Drives the ALU-control interface from the producing side:
  - ALUOp_o[1:0]
  - funct_o[9:0], laid out as {funct7, funct3}
- Also sequences the register-file, memory and PC enables for a multi-cycle datapath variant of the CPU.
- Fetches instructions over a valid/ready handshake with instruction memory.

Parameters:
- RESET_STATE, 3'd0 (FETCH): state entered on reset.
- CNT_W, 32: width of the retired-instruction counter (optional feature only).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset.
- instr_i  in  32  instruction word from instruction memory.
- instr_valid_i  in  1  instr_i is valid.
- instr_ready_o  out  1  block accepts an instruction this cycle.
- zero_i  in  1  ALU zero flag, sampled in EXEC.
- ALUOp_o  out  2  ALU-control operation class.
- funct_o  out  10  {instr[31:25], instr[14:12]}, held for the whole instruction.
- ALUSrc_o  out  1  immediate selects ALU operand B.
- RegWrite_o  out  1  register-file write strobe.
- MemRead_o  out  1  data-memory read strobe.
- MemWrite_o  out  1  data-memory write strobe.
- MemtoReg_o  out  1  write-back selects memory data.
- PCWrite_o  out  1  PC update strobe.
- PCSrc_o  out  1  PC update uses branch target.
- error_o  out  1  one-cycle pulse on an unsupported opcode.
- state_o  out  3  current state, for debug.

Behaviour:
- Interface decisions:
  - One clock, clk_i.
  - Reset rst_i is asynchronous and active-high.
  - While rst_i is high: state = FETCH; instruction register = 0; all outputs 0 except instr_ready_o.
  - instr_ready_o follows the state (high in FETCH), including during reset.
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5–7 are illegal and recover to FETCH on the next clock.
- FETCH:
  - instr_ready_o=1.
  - On instr_valid_i && instr_ready_o: latch instr_i, go to DECODE.
  - Otherwise stay in FETCH; all strobes stay 0.
- DECODE:
  - Classify opcode = instr[6:0]:
    - R = 0110011
    - I-arith = 0010011
    - LW = 0000011
    - SW = 0100011
    - BEQ = 1100011
  - Unsupported opcode: pulse error_o, go to FETCH with no strobes, then continue normally.
  - Otherwise go to EXEC.
- ALUOp_o and ALUSrc_o are valid from DECODE through the last state of the instruction; both are 0 in FETCH.
- ALUOp encodings:
  - R → 2'b10.
  - I-arith, LW, SW → 2'b00; ALU control resolves add/srai etc. from funct3/funct7.
  - BEQ → 2'b01.
  - 2'b11 is never driven.
- ALUSrc_o=1 for I-arith, LW and SW.
- EXEC:
  - R / I-arith → WB.
  - LW / SW → MEM.
  - BEQ → FETCH, asserting PCWrite_o=1 with PCSrc_o=zero_i.
- MEM:
  - LW: MemRead_o=1 → WB.
  - SW: MemWrite_o=1 → FETCH with PCWrite_o=1, PCSrc_o=0.
- WB:
  - RegWrite_o=1; MemtoReg_o=1 for LW only.
  - PCWrite_o=1, PCSrc_o=0 → FETCH.
- All strobes are single-cycle, Moore outputs decoded from state plus latched opcode (no combinational path from instr_i).
- Latency from accepting handshake cycle to next FETCH:
  - R / I-arith / SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ: 3 cycles.
  - Illegal opcode: 2 cycles.
- instr_valid_i is ignored outside FETCH. Reset mid-instruction aborts with no further strobes.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_PERF_EN.
- When defined:
  - Adds output retired_o[CNT_W-1:0], reset to 0.
  - Increments on each final-state exit (BEQ EXEC, SW MEM, WB).
  - Wraps modulo 2^CNT_W.
  - Illegal opcodes are not counted.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - opcode localparams (R, I, LW, SW, BEQ);
  - ALUOp encodings (ALUOP_R=10, ALUOP_I=00, ALUOP_BR=01);
  - state encodings FETCH..WB.
- One natural sub-module: control_decode, which is combinational, maps opcode to class bits plus ALUOp/ALUSrc, and is shared with the single-cycle Control.

Test Plan:
- Reset mid-EXEC with rst_i pulsed asynchronously between clock edges → outputs clear immediately; state_o=0 without waiting for a clock edge.
- Present 0x40505293 (srai x5,x0,5) at reset release → FETCH→DECODE→EXEC→WB, with:
  - funct_o = 10'b0100000101, ALUOp_o=00, ALUSrc_o=1;
  - RegWrite_o and PCWrite_o high only in WB;
  - instr_ready_o high again 4 cycles after the handshake.
- Present 0x40B50533 (sub x10,x10,x11) → ALUOp_o=10, funct_o = 10'b0100000000, ALUSrc_o=0, RegWrite_o in WB.
- Present lw 0x00012283 then sw 0x00512223 back-to-back with instr_valid_i held high:
  - lw takes 5 cycles (MemRead_o in MEM, MemtoReg_o=1 in WB);
  - sw takes 4 cycles (MemWrite_o in MEM, RegWrite_o never asserted);
  - each instruction is accepted exactly once.
- Present beq 0x00B50463 twice, with zero_i=1 then zero_i=0 in EXEC → ALUOp_o=01; PCWrite_o=1 with PCSrc_o=1, then PCSrc_o=0; 3 cycles each.
- Present illegal opcode 0x0000007F → error_o pulses once in DECODE; no strobes; FETCH next cycle. With MULTICYCLE_CONTROL_PERF_EN defined, retired_o shows 0 after illegal-only stimulus and 5 after the five legal instructions above.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle main control and its opcode decoder.
// Optional retired-instruction counter: MULTICYCLE_CONTROL_PERF_EN.
package multicycle_control_pkg;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_R  = 2'b10;
  localparam logic [1:0] ALUOP_I  = 2'b00;
  localparam logic [1:0] ALUOP_BR = 2'b01;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  typedef struct packed {
    logic       is_r;
    logic       is_i;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       legal;
    logic [1:0] aluop;
    logic       alusrc;
  } ctrl_cls_t;

  function automatic logic [9:0] funct_of(
    input logic [31:0] ins
  );
    return {ins[31:25], ins[14:12]};
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier, shared with the single-cycle Control.
// Produces class bits plus ALUOp/ALUSrc for the five supported opcodes.
module control_decode
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode_i,
  output ctrl_cls_t  cls_o
);

  always_comb begin
    cls_o = '0;
    unique case (opcode_i)
      OPC_R: begin
        cls_o.is_r  = 1'b1;
        cls_o.legal = 1'b1;
        cls_o.aluop = ALUOP_R;
      end
      OPC_I: begin
        cls_o.is_i   = 1'b1;
        cls_o.legal  = 1'b1;
        cls_o.aluop  = ALUOP_I;
        cls_o.alusrc = 1'b1;
      end
      OPC_LW: begin
        cls_o.is_lw  = 1'b1;
        cls_o.legal  = 1'b1;
        cls_o.aluop  = ALUOP_I;
        cls_o.alusrc = 1'b1;
      end
      OPC_SW: begin
        cls_o.is_sw  = 1'b1;
        cls_o.legal  = 1'b1;
        cls_o.aluop  = ALUOP_I;
        cls_o.alusrc = 1'b1;
      end
      OPC_BEQ: begin
        cls_o.is_beq = 1'b1;
        cls_o.legal  = 1'b1;
        cls_o.aluop  = ALUOP_BR;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Define MULTICYCLE_CONTROL_PERF_EN to add the retired_o counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter logic [2:0] RESET_STATE = ST_FETCH
`ifdef MULTICYCLE_CONTROL_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic        zero_i,
  output logic [1:0]  ALUOp_o,
  output logic [9:0]  funct_o,
  output logic        ALUSrc_o,
  output logic        RegWrite_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        MemtoReg_o,
  output logic        PCWrite_o,
  output logic        PCSrc_o,
  output logic        error_o,
  output logic [2:0]  state_o
`ifdef MULTICYCLE_CONTROL_PERF_EN
  ,
  output logic [CNT_W-1:0] retired_o
`endif
);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [31:0] r_instr;
  ctrl_cls_t   w_cls;
  logic        w_unused_instr;

  control_decode u_dec (
    .opcode_i (r_instr[6:0]),
    .cls_o    (w_cls)
  );

  assign w_unused_instr = ^{r_instr[24:15], r_instr[11:7]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RESET_STATE;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      if (instr_ready_o && instr_valid_i)
        r_instr <= instr_i;
    end
  end

  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH:
        w_next = instr_valid_i ? ST_DECODE : ST_FETCH;
      ST_DECODE:
        w_next = w_cls.legal ? ST_EXEC : ST_FETCH;
      ST_EXEC: begin
        if (w_cls.is_r || w_cls.is_i)
          w_next = ST_WB;
        else if (w_cls.is_lw || w_cls.is_sw)
          w_next = ST_MEM;
        else
          w_next = ST_FETCH;
      end
      ST_MEM:
        w_next = w_cls.is_lw ? ST_WB : ST_FETCH;
      default:
        w_next = ST_FETCH;
    endcase
  end

  // Moore outputs: state plus the latched opcode only.
  always_comb begin
    instr_ready_o = (r_state == ST_FETCH);
    ALUOp_o       = 2'b00;
    ALUSrc_o      = 1'b0;
    RegWrite_o    = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    MemtoReg_o    = 1'b0;
    PCWrite_o     = 1'b0;
    PCSrc_o       = 1'b0;
    error_o       = 1'b0;
    case (r_state)
      ST_DECODE: begin
        ALUOp_o  = w_cls.aluop;
        ALUSrc_o = w_cls.alusrc;
        error_o  = ~w_cls.legal;
      end
      ST_EXEC: begin
        ALUOp_o  = w_cls.aluop;
        ALUSrc_o = w_cls.alusrc;
        if (w_cls.is_beq) begin
          PCWrite_o = 1'b1;
          PCSrc_o   = zero_i;
        end
      end
      ST_MEM: begin
        ALUOp_o    = w_cls.aluop;
        ALUSrc_o   = w_cls.alusrc;
        MemRead_o  = w_cls.is_lw;
        MemWrite_o = w_cls.is_sw;
        PCWrite_o  = w_cls.is_sw;
      end
      ST_WB: begin
        ALUOp_o    = w_cls.aluop;
        ALUSrc_o   = w_cls.alusrc;
        RegWrite_o = 1'b1;
        MemtoReg_o = w_cls.is_lw;
        PCWrite_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign funct_o = funct_of(r_instr);
  assign state_o = r_state;

`ifdef MULTICYCLE_CONTROL_PERF_EN
  logic [CNT_W-1:0] r_retired;

  // Every final-state exit of a legal instruction updates the PC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_retired <= '0;
    else if (PCWrite_o)
      r_retired <= r_retired + CNT_W'(1);
  end

  assign retired_o = r_retired;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: strobe events are queued at issue
// and checked by an independent negedge monitor; latencies checked inline.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic        zero_i;
  logic [1:0]  ALUOp_o;
  logic [9:0]  funct_o;
  logic        ALUSrc_o;
  logic        RegWrite_o;
  logic        MemRead_o;
  logic        MemWrite_o;
  logic        MemtoReg_o;
  logic        PCWrite_o;
  logic        PCSrc_o;
  logic        error_o;
  logic [2:0]  state_o;
`ifdef MULTICYCLE_CONTROL_PERF_EN
  logic [31:0] retired_o;
`endif

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .zero_i        (zero_i),
    .ALUOp_o       (ALUOp_o),
    .funct_o       (funct_o),
    .ALUSrc_o      (ALUSrc_o),
    .RegWrite_o    (RegWrite_o),
    .MemRead_o     (MemRead_o),
    .MemWrite_o    (MemWrite_o),
    .MemtoReg_o    (MemtoReg_o),
    .PCWrite_o     (PCWrite_o),
    .PCSrc_o       (PCSrc_o),
    .error_o       (error_o),
    .state_o       (state_o)
`ifdef MULTICYCLE_CONTROL_PERF_EN
    ,
    .retired_o     (retired_o)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] aluop;
    logic [9:0] funct;
    logic       src;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic       pcw;
    logic       pcs;
    logic       err;
  } ev_t;

  localparam logic [31:0] I_SRAI = 32'h40505293;
  localparam logic [31:0] I_SUB  = 32'h40B50533;
  localparam logic [31:0] I_LW   = 32'h00012283;
  localparam logic [31:0] I_SW   = 32'h00512223;
  localparam logic [31:0] I_BEQ  = 32'h00B50463;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  ev_t sbq[$];
  int  checks = 0;
  int  fails  = 0;
  int  hs     = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [1:0] aluop,
                      input logic [9:0] funct, input logic src,
                      input logic rw, input logic mr, input logic mw,
                      input logic m2r, input logic pcw, input logic pcs,
                      input logic err);
    ev_t e;
    e = {st, aluop, funct, src, rw, mr, mw, m2r, pcw, pcs, err};
    sbq.push_back(e);
  endtask

  always @(posedge clk)
    if (!rst_i && instr_valid_i && instr_ready_o)
      hs++;

  always @(negedge clk) begin
    ev_t act;
    ev_t e;
    if (!rst_i && (RegWrite_o || MemRead_o || MemWrite_o ||
                   PCWrite_o || error_o)) begin
      act = {state_o, ALUOp_o, funct_o, ALUSrc_o, RegWrite_o,
             MemRead_o, MemWrite_o, MemtoReg_o, PCWrite_o,
             PCSrc_o, error_o};
      checks++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event got=%h exp=none", act);
      end else begin
        e = sbq.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL event got=%h exp=%h", act, e);
        end
      end
    end
  end

  task automatic count_lat(output int lat);
    lat = 1;
    while (state_o != ST_FETCH && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic go(input logic [31:0] ins, input logic z,
                    input logic [1:0] ex_aluop, input logic ex_src,
                    input int ex_lat, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, "_ready"}, {31'd0, instr_ready_o}, 32'd1);
    instr_i       = ins;
    instr_valid_i = 1'b1;
    zero_i        = z;
    @(posedge clk);
    #1;
    instr_valid_i = 1'b0;
    chk({nm, "_dec"}, {29'd0, ALUOp_o, ALUSrc_o}, {29'd0, ex_aluop, ex_src});
    count_lat(lat);
    chk({nm, "_lat"}, lat, ex_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int hs0;
    rst_i         = 1'b1;
    instr_i       = '0;
    instr_valid_i = 1'b0;
    zero_i        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {29'd0, state_o}, 32'd0);
    chk("rst_ready", {31'd0, instr_ready_o}, 32'd1);
    chk("rst_outs", {17'd0, ALUOp_o, funct_o, ALUSrc_o, RegWrite_o,
                     MemRead_o, MemWrite_o, MemtoReg_o, PCWrite_o,
                     PCSrc_o, error_o}, 32'd0);
`ifdef MULTICYCLE_CONTROL_PERF_EN
    chk("rst_retired", retired_o, 32'd0);
`endif
    @(negedge clk);
    rst_i = 1'b0;

    push(ST_WB, 2'b00, 10'b0100000101, 1, 1, 0, 0, 0, 1, 0, 0);
    go(I_SRAI, 1'b0, 2'b00, 1'b1, 4, "srai");

    push(ST_WB, 2'b10, 10'b0100000000, 0, 1, 0, 0, 0, 1, 0, 0);
    go(I_SUB, 1'b0, 2'b10, 1'b0, 4, "sub");

    push(ST_MEM, 2'b00, 10'b0000000010, 1, 0, 1, 0, 0, 0, 0, 0);
    push(ST_WB, 2'b00, 10'b0000000010, 1, 1, 0, 0, 1, 1, 0, 0);
    push(ST_MEM, 2'b00, 10'b0000000010, 1, 0, 0, 1, 0, 1, 0, 0);
    hs0 = hs;
    @(negedge clk);
    instr_i       = I_LW;
    instr_valid_i = 1'b1;
    @(posedge clk);
    #1;
    instr_i = I_SW;
    count_lat(lat);
    chk("lw_lat", lat, 5);
    @(posedge clk);
    #1;
    instr_valid_i = 1'b0;
    count_lat(lat);
    chk("sw_lat", lat, 4);
    chk("lwsw_accepts", hs - hs0, 2);

    push(ST_EXEC, 2'b01, 10'b0000000000, 0, 0, 0, 0, 0, 1, 1, 0);
    go(I_BEQ, 1'b1, 2'b01, 1'b0, 3, "beq_t");
`ifdef MULTICYCLE_CONTROL_PERF_EN
    chk("retired_5", retired_o, 32'd5);
`endif
    push(ST_EXEC, 2'b01, 10'b0000000000, 0, 0, 0, 0, 0, 1, 0, 0);
    go(I_BEQ, 1'b0, 2'b01, 1'b0, 3, "beq_nt");
`ifdef MULTICYCLE_CONTROL_PERF_EN
    chk("retired_6", retired_o, 32'd6);
`endif

    // Asynchronous reset between edges while in EXEC.
    @(negedge clk);
    instr_i       = I_SUB;
    instr_valid_i = 1'b1;
    @(posedge clk);
    #1;
    instr_valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_exec", {29'd0, state_o}, {29'd0, ST_EXEC});
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_state", {29'd0, state_o}, 32'd0);
    chk("arst_ready", {31'd0, instr_ready_o}, 32'd1);
    chk("arst_outs", {17'd0, ALUOp_o, funct_o, ALUSrc_o, RegWrite_o,
                      MemRead_o, MemWrite_o, MemtoReg_o, PCWrite_o,
                      PCSrc_o, error_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold", {29'd0, state_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
`ifdef MULTICYCLE_CONTROL_PERF_EN
    chk("retired_rst", retired_o, 32'd0);
`endif

    push(ST_DECODE, 2'b00, 10'b0000000000, 0, 0, 0, 0, 0, 0, 0, 1);
    go(I_ILL, 1'b0, 2'b00, 1'b0, 2, "ill");
`ifdef MULTICYCLE_CONTROL_PERF_EN
    chk("retired_ill", retired_o, 32'd0);
`endif

    push(ST_WB, 2'b10, 10'b0100000000, 0, 1, 0, 0, 0, 1, 0, 0);
    go(I_SUB, 1'b0, 2'b10, 1'b0, 4, "sub2");
`ifdef MULTICYCLE_CONTROL_PERF_EN
    chk("retired_1", retired_o, 32'd1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("idle_state", {29'd0, state_o}, 32'd0);
    chk("idle_ready", {31'd0, instr_ready_o}, 32'd1);
    chk("sb_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
